// File: rtl/quad_gen.sv
// Quadrature A/B generator: one Gray-code step per 'per' clocks for each accepted signed move command.
// First edge lands per clocks after accept; cmd_ready is low while a move runs and the upstream must hold its command.
module quad_gen #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CNT_W-1:0] cmd_steps,
  input  logic        [DIV_W-1:0] cmd_period,
  input  logic                    abort,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic                    done,
  output logic signed [63:0]      position
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic [DIV_W-1:0] r_per;
  logic [DIV_W-1:0] r_timer;
  logic [1:0]       r_phase;
  logic             r_a;
  logic             r_b;
  logic             r_done;
  logic [63:0]      r_pos;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [CNT_W-1:0] w_abs;
  logic [DIV_W-1:0] w_per_in;
  logic [1:0]       w_phase_nxt;

  // Unsigned magnitude so the most negative step count maps to 2^(CNT_W-1) exactly.
  assign w_abs       = cmd_steps[CNT_W-1] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);
  assign w_per_in    = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
  // Phase index 0..3 maps to ab = 00,10,11,01; r_dir=1 walks it backwards.
  assign w_phase_nxt = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign a         = r_a;
  assign b         = r_b;
  assign done      = r_done;
  assign position  = r_pos;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && (cmd_steps != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == DIV_W'(1)) begin
          w_step = 1'b1;
          if (r_rem == CNT_W'(1)) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_per   <= '0;
      r_timer <= '0;
      r_phase <= 2'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_done  <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_rem   <= w_abs;
        r_dir   <= cmd_steps[CNT_W-1];
        r_per   <= w_per_in;
        r_timer <= w_per_in;
      end else if (w_step) begin
        r_rem   <= r_rem - CNT_W'(1);
        r_timer <= r_per;
        r_phase <= w_phase_nxt;
        r_a     <= w_phase_nxt[1] ^ w_phase_nxt[0];
        r_b     <= w_phase_nxt[1];
        r_pos   <= r_dir ? (r_pos - 64'd1) : (r_pos + 64'd1);
      end else if ((r_state == S_RUN) && !abort) begin
        r_timer <= r_timer - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen: hand-computed a/b, position, busy and done at each step of each scenario.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_quad_gen;

  logic               clk = 1'b0;
  logic               resetn;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [31:0] cmd_steps;
  logic        [15:0] cmd_period;
  logic               abort;
  logic               a;
  logic               b;
  logic               busy;
  logic               done;
  logic signed [63:0] position;

  int vecs = 0;
  int errs = 0;

  logic [1:0] fwd_seq [0:4] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_seq [0:2] = '{2'b01, 2'b11, 2'b10};
  logic [1:0] hold_ab   [1:9] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
  logic       hold_busy [1:9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       hold_done [1:9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         hold_pos  [1:9] = '{1, 2, 2, 3, 3, 3, 4, 4, 5};

  quad_gen #(.CNT_W(32), .DIV_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [31:0] steps, input logic [15:0] per);
    cmd_steps  = steps;
    cmd_period = per;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn     = 1'b0;
    cmd_valid  = 1'b1;
    cmd_steps  = 32'sd5;
    cmd_period = 16'd1;
    abort      = 1'b0;
    repeat (3) tick();
    chk("rst_ab", {a, b}, 2'b00);
    chk("rst_pos", position, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    cmd_valid = 1'b0;
    resetn    = 1'b1;
    tick();
    chk("rst_rdy", cmd_ready, 1'b1);
    chk("rst_idle_busy", busy, 1'b0);

    // forward +4, period 3
    send(32'sd4, 16'd3);
    chk("fwd_acc_busy", busy, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("fwd_ab", {a, b}, fwd_seq[c/3]);
      chk("fwd_pos", position, 64'(c/3));
      chk("fwd_busy", busy, c < 12);
      chk("fwd_done", done, c == 12);
    end
    chk("fwd_rdy", cmd_ready, 1'b1);

    // reverse -3, period 0 (treated as 1)
    do_reset();
    send(-32'sd3, 16'd0);
    chk("rev_acc_ab", {a, b}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rev_ab", {a, b}, rev_seq[i]);
      chk("rev_pos", position, 64'(-(i + 1)));
      chk("rev_done", done, i == 2);
    end
    chk("rev_busy_end", busy, 1'b0);

    // abort +10 / period 5 at +12, then -1
    do_reset();
    send(32'sd10, 16'd5);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("abt_run_done", done, 1'b0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_busy", busy, 1'b0);
    chk("abt_rdy", cmd_ready, 1'b1);
    chk("abt_done", done, 1'b0);
    chk("abt_pos", position, 64'd2);
    chk("abt_ab", {a, b}, 2'b11);
    repeat (3) tick();
    chk("abt_hold_ab", {a, b}, 2'b11);
    chk("abt_hold_pos", position, 64'd2);
    send(-32'sd1, 16'd2);
    tick();
    tick();
    chk("abt_rev_ab", {a, b}, 2'b10);
    chk("abt_rev_pos", position, 64'd1);
    chk("abt_rev_done", done, 1'b1);

    // zero-step command is a one-cycle no-op
    send(32'sd0, 16'd4);
    chk("zero_busy", busy, 1'b0);
    chk("zero_rdy", cmd_ready, 1'b1);
    chk("zero_pos", position, 64'd1);
    tick();
    chk("zero_done", done, 1'b0);

    // command held valid through a 2-step move; re-accepted only at the done edge
    cmd_steps  = 32'sd2;
    cmd_period = 16'd2;
    cmd_valid  = 1'b1;
    tick();
    chk("hold_acc_busy", busy, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("hold_ab", {a, b}, hold_ab[c]);
      chk("hold_busy", busy, hold_busy[c]);
      chk("hold_done", done, hold_done[c]);
      chk("hold_pos", position, 64'(hold_pos[c]));
      if (c == 5) cmd_valid = 1'b0;
    end

    // reset in the middle of a move, then the most negative step count
    send(32'sd5, 16'd2);
    repeat (7) tick();
    chk("mid_pre_pos", position, 64'd8);
    resetn = 1'b0;
    tick();
    chk("mid_ab", {a, b}, 2'b00);
    chk("mid_pos", position, 64'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    resetn = 1'b1;
    tick();
    chk("mid_rdy", cmd_ready, 1'b1);
    send(32'sh8000_0000, 16'd1);
    chk("min_busy", busy, 1'b1);
    chk("min_rem", dut.r_rem, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("min_ab", {a, b}, rev_seq[i]);
      chk("min_pos", position, 64'(-(i + 1)));
    end
    chk("min_rem_dec", dut.r_rem, 32'h7FFF_FFFD);
    chk("min_busy_run", busy, 1'b1);
    chk("min_done", done, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("min_abort_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
